// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 data mux between four packet producers.
// The mux select is locked onto the winner until its last beat is accepted downstream.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;

  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       xfer_last;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    out_data = din0;
      2'd1:    out_data = din1;
      2'd2:    out_data = din2;
      default: out_data = din3;
    endcase
  end

  // Handshake: a beat moves when out_valid & out_ready are both high at a rising edge;
  // the granted producer holds req/last/din stable until then, and out_valid never
  // depends on out_ready.
  assign out_valid = (state_q == BUSY) & req[sel_q];
  assign out_last  = out_valid & last[sel_q];
  assign xfer_last = out_valid & out_ready & out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= BUSY;
            sel_q   <= pick;
            gnt_q   <= 4'b0001 << pick;
          end
        end
        BUSY: begin
          // sel_q is left alone on release so the mux stays quiet through the bubble.
          if (xfer_last) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            ptr_q   <= sel_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign dbg_state = (state_q == BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomised and directed bench for mux4_rr_arbiter, checked against a cycle-level
// reference model of the arbitration rules through an expected-output queue.
module tb_mux4_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   last;
  logic [W-1:0] din0, din1, din2, din3;
  logic         out_ready;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         dbg_state;

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  // {busy, gnt[3:0], sel[1:0], valid, last, data[7:0]}
  logic [16:0] exp_q[$];

  // ---------------- reference model ----------------
  int m_owner = -1;   // granted port, -1 when nobody holds the mux
  int m_ptr   = 0;    // first port to consider on the next arbitration
  int m_sel   = 0;    // last port the mux pointed at
  int xfer_port = -1; // port whose beat moved in the most recent cycle

  // producer state for the random phase
  int         rem [4];
  logic [7:0] cd  [4];
  logic       pr  [4];

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_sel     = 0;
    xfer_port = -1;
  endtask

  // Drives one cycle of inputs, records the expected outputs for it, then advances
  // the model across the following rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3,
                      input logic rdy);
    logic [7:0] d [4];
    logic [3:0] e_gnt;
    logic       e_valid, e_last;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    req = r; last = l; din0 = d0; din1 = d1; din2 = d2; din3 = d3; out_ready = rdy;

    if (m_owner < 0) begin
      e_gnt = 4'b0000; e_valid = 1'b0; e_last = 1'b0;
    end else begin
      e_gnt   = 4'(1 << m_owner);
      e_valid = r[m_owner];
      e_last  = r[m_owner] & l[m_owner];
    end
    exp_q.push_back({(m_owner >= 0), e_gnt, 2'(m_sel), e_valid, e_last, d[m_sel]});

    xfer_port = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
        end
      end
    end else if (e_valid && rdy) begin
      xfer_port = m_owner;
      if (e_last) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",   16'(gnt),       16'h0);
    chk("rst_sel",   16'(sel),       16'h0);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_last",  16'(out_last),  16'h0);
    chk("rst_data",  16'(out_data),  16'(din0));
    chk("rst_state", 16'(dbg_state), 16'h0);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; pr[i] = 1'b0; cd[i] = 8'h00;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [16:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {dbg_state, gnt, sel, out_valid, out_last, out_data};
      vec_cnt++;
      if (got_v !== exp_v) begin
        err_cnt++;
        $display("FAIL cycle_out: got busy=%b gnt=%b sel=%0d v=%b l=%b d=%h expected busy=%b gnt=%b sel=%0d v=%b l=%b d=%h at %0t",
                 got_v[16], got_v[15:12], got_v[11:10], got_v[9], got_v[8], got_v[7:0],
                 exp_v[16], exp_v[15:12], exp_v[11:10], exp_v[9], exp_v[8], exp_v[7:0], $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] rq, lst;
    rst_n = 1'b0;
    req = 4'b0; last = 4'b0; out_ready = 1'b0;
    din0 = 8'hA0; din1 = 8'hA1; din2 = 8'hA2; din3 = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; pr[i] = 1'b0; cd[i] = 8'h00;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // idle: no requests
    for (int n = 0; n < 10; n++) step(4'b0000, 4'b0000, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);

    // everyone requesting single-beat packets: 0,1,2,3,0 with bubbles
    for (int n = 0; n < 10; n++) step(4'b1111, 4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1'b1);

    // port 2 three-beat packet, port 0 arrives mid-packet
    do_reset();
    step(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h11, 8'h00, 1'b1);
    step(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h11, 8'h00, 1'b1);
    step(4'b0101, 4'b0000, 8'h5A, 8'h00, 8'h22, 8'h00, 1'b1);
    step(4'b0101, 4'b0100, 8'h5A, 8'h00, 8'h33, 8'h00, 1'b1);
    step(4'b0001, 4'b0001, 8'h5A, 8'h00, 8'h33, 8'h00, 1'b1);
    step(4'b0001, 4'b0001, 8'h5A, 8'h00, 8'h33, 8'h00, 1'b1);
    step(4'b0000, 4'b0000, 8'h5A, 8'h00, 8'h33, 8'h00, 1'b1);

    // port 1 two-beat packet with out_ready 1,0,0,1
    step(4'b0010, 4'b0000, 8'h00, 8'hB1, 8'h00, 8'h00, 1'b1);
    step(4'b0010, 4'b0000, 8'h00, 8'hB1, 8'h00, 8'h00, 1'b1);
    step(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b0);
    step(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b0);
    step(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b1);
    step(4'b0000, 4'b0000, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b1);

    // port 3 drops req mid-packet while port 1 waits; ptr wraps to 0
    step(4'b1010, 4'b0000, 8'h00, 8'hC9, 8'h00, 8'hC1, 1'b1);
    step(4'b1010, 4'b0000, 8'h00, 8'hC9, 8'h00, 8'hC1, 1'b1);
    step(4'b0010, 4'b0000, 8'h00, 8'hC9, 8'h00, 8'hC2, 1'b1);
    step(4'b0010, 4'b0000, 8'h00, 8'hC9, 8'h00, 8'hC2, 1'b1);
    step(4'b1010, 4'b1000, 8'h00, 8'hC9, 8'h00, 8'hC2, 1'b1);
    step(4'b0010, 4'b0010, 8'h00, 8'hC9, 8'h00, 8'hC2, 1'b1);
    step(4'b0010, 4'b0010, 8'h00, 8'hC9, 8'h00, 8'hC2, 1'b1);
    step(4'b0000, 4'b0000, 8'h00, 8'hC9, 8'h00, 8'hC2, 1'b1);

    // reset in the middle of a four-beat packet on port 1
    step(4'b0010, 4'b0000, 8'h00, 8'hD1, 8'h00, 8'h00, 1'b1);
    step(4'b0010, 4'b0000, 8'h00, 8'hD1, 8'h00, 8'h00, 1'b1);
    step(4'b0010, 4'b0000, 8'h00, 8'hD2, 8'h00, 8'h00, 1'b1);
    do_reset();
    for (int n = 0; n < 6; n++) step(4'b0110, 4'b0110, 8'h00, 8'hE1, 8'hE2, 8'h00, 1'b1);

    // random producers obeying the hold-until-transfer rule
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (xfer_port == i) begin
          rem[i]--;
          if (rem[i] == 0) pr[i] = 1'b0;
          else begin
            cd[i] = 8'($urandom);
            pr[i] = ($urandom_range(0, 4) != 0);
          end
        end else if (!pr[i]) begin
          if (rem[i] > 0) begin
            if ($urandom_range(0, 1) == 1) pr[i] = 1'b1;
          end else if ($urandom_range(0, 2) == 0) begin
            rem[i] = $urandom_range(1, 4);
            cd[i]  = 8'($urandom);
            pr[i]  = 1'b1;
          end
        end
        rq[i]  = pr[i];
        lst[i] = (rem[i] == 1);
      end
      step(rq, lst, cd[0], cd[1], cd[2], cd[3], ($urandom_range(0, 9) < 7));
      if (n == 1000 || n == 2200) do_reset();
    end

    @(negedge clk); #1;
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
